// File: rtl/heart_hit_manager.sv
// heart_hit_manager
//   Consumes the bullet sprite stage output, detects per-frame overlap of the
//   bullet with the player heart, applies damage, runs an invulnerability
//   window and flags game over.
//
// Ports:
//   Pclk           pixel clock, all logic on rising edge
//   rst            asynchronous active-high reset
//   xx, yy         current scan position
//   aactive        active-video strobe (aligned with xx/yy)
//   BulletSpriteOn bullet pixel, lags xx/yy by one cycle
//   HeartSpriteOn  heart pixel, lags xx/yy by one cycle
//   game_start     one-cycle restart pulse
//   isCollisionB1  high while invulnerable; bullet stage blanks the bullet
//   hp             current hit points
//   game_over      high once hit points are exhausted
//   heart_blink    heart visibility (toggles every 8 frames while invulnerable)
//   hit_count      registered-hit counter, saturating (HEART_HIT_COUNT_EN only)
//
// Optional feature macro: HEART_HIT_COUNT_EN adds the hit_count output.

module heart_hit_manager #(
   parameter int unsigned MAX_HP        = 20,
   parameter int unsigned DAMAGE        = 4,
   parameter int unsigned INVULN_FRAMES = 60
) (
   input  logic       Pclk,
   input  logic       rst,
   input  logic [9:0] xx,
   input  logic [9:0] yy,
   input  logic       aactive,
   input  logic       BulletSpriteOn,
   input  logic       HeartSpriteOn,
   input  logic       game_start,
`ifdef HEART_HIT_COUNT_EN
   output logic [7:0] hit_count,
`endif
   output logic       isCollisionB1,
   output logic [6:0] hp,
   output logic       game_over,
   output logic       heart_blink
);

   localparam logic [1:0] StAlive  = 2'd0;
   localparam logic [1:0] StInvuln = 2'd1;
   localparam logic [1:0] StDead   = 2'd2;

   localparam logic [6:0] MaxHp      = 7'(MAX_HP);
   localparam logic [6:0] Damage     = 7'(DAMAGE);
   localparam logic [7:0] Damage8    = 8'(DAMAGE);
   localparam logic [7:0] InvulnLoad = 8'(INVULN_FRAMES - 1);

   logic [1:0] state_q, state_d;
   logic [6:0] hp_q, hp_d;
   logic [7:0] invuln_cnt_q, invuln_cnt_d;
   logic       hit_pending_q, hit_pending_d;
   logic       aactive_d_q, aactive_d_d;
   logic       eval_q, eval_d;
   logic       coll_q, coll_d;
   logic       game_over_q, game_over_d;
   logic       blink_q, blink_d;

   logic tick;
   logic ov;
   logic frame_hit;
   logic reg_hit;

   always_comb begin
      // Sprite-on inputs lag the scan position by a cycle, so aactive is
      // delayed to match before qualifying the overlap.
      tick      = (xx == 10'd639) && (yy == 10'd479);
      ov        = aactive_d_q & BulletSpriteOn & HeartSpriteOn;
      // The eval cycle carries the overlap of pixel (639,479) itself.
      frame_hit = hit_pending_q | ov;

      state_d       = state_q;
      hp_d          = hp_q;
      invuln_cnt_d  = invuln_cnt_q;
      hit_pending_d = hit_pending_q | ov;
      aactive_d_d   = aactive;
      eval_d        = tick;
      reg_hit       = 1'b0;

      if (eval_q) begin
         hit_pending_d = 1'b0;
         case (state_q)
            StAlive: begin
               if (frame_hit) begin
                  reg_hit = 1'b1;
                  // 8-bit compare so hp values near the top never wrap.
                  if ({1'b0, hp_q} > Damage8) begin
                     hp_d         = hp_q - Damage;
                     invuln_cnt_d = InvulnLoad;
                     state_d      = StInvuln;
                  end else begin
                     hp_d    = 7'd0;
                     state_d = StDead;
                  end
               end
            end
            StInvuln: begin
               if (invuln_cnt_q == 8'd0) begin
                  state_d = StAlive;
               end else begin
                  invuln_cnt_d = invuln_cnt_q - 8'd1;
               end
            end
            StDead: begin
               hp_d = 7'd0;
            end
            default: begin
               state_d = StAlive;
            end
         endcase
      end

      // Restart overrides any decision taken in the same cycle.
      if (game_start) begin
         hp_d          = MaxHp;
         invuln_cnt_d  = 8'd0;
         hit_pending_d = 1'b0;
         state_d       = StAlive;
         reg_hit       = 1'b0;
      end

      coll_d      = (state_d == StInvuln);
      game_over_d = (state_d == StDead);
      blink_d     = (state_d == StInvuln) ? invuln_cnt_d[3] : 1'b1;
   end

   always_ff @(posedge Pclk or posedge rst) begin
      if (rst) begin
         state_q       <= StAlive;
         hp_q          <= MaxHp;
         invuln_cnt_q  <= 8'd0;
         hit_pending_q <= 1'b0;
         aactive_d_q   <= 1'b0;
         eval_q        <= 1'b0;
         coll_q        <= 1'b0;
         game_over_q   <= 1'b0;
         blink_q       <= 1'b1;
      end else begin
         state_q       <= state_d;
         hp_q          <= hp_d;
         invuln_cnt_q  <= invuln_cnt_d;
         hit_pending_q <= hit_pending_d;
         aactive_d_q   <= aactive_d_d;
         eval_q        <= eval_d;
         coll_q        <= coll_d;
         game_over_q   <= game_over_d;
         blink_q       <= blink_d;
      end
   end

`ifdef HEART_HIT_COUNT_EN
   logic [7:0] hit_count_q, hit_count_d;

   always_comb begin
      hit_count_d = hit_count_q;
      if (game_start) begin
         hit_count_d = 8'd0;
      end else if (reg_hit && (hit_count_q != 8'hff)) begin
         hit_count_d = hit_count_q + 8'd1;
      end
   end

   always_ff @(posedge Pclk or posedge rst) begin
      if (rst) begin
         hit_count_q <= 8'd0;
      end else begin
         hit_count_q <= hit_count_d;
      end
   end

   assign hit_count = hit_count_q;
`endif

   assign isCollisionB1 = coll_q;
   assign hp            = hp_q;
   assign game_over     = game_over_q;
   assign heart_blink   = blink_q;

endmodule
